// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared types for the RV32M multiply/divide unit.
//   XLEN_DEF       default operand/result width
//   UNIT_MD        decode_bus.unit code that selects this unit
//   decode_bus     dispatched decode bus (unit + funct3)
//   muldiv_op_e    funct3 encoding of the M-extension ops
//   muldiv_state_e sequencing states of muldiv_unit
package muldiv_unit_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] UNIT_MD = 2'd3;

  typedef struct packed {
    logic [1:0] unit;
    logic [2:0] sel;
  } decode_bus;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  function automatic logic rs1_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: dispatch and write-back bundle of muldiv_unit.
//   dispatch side : decode_i, valid_i, rs1_i, rs2_i, rd_i, flush -> unit; ok_o <- unit
//   write-back    : res_data, res_adr, res_v <- unit; res_ok -> unit
//   master = dispatch stage / write-back port, slave = muldiv_unit
interface muldiv_unit_if #(parameter int XLEN = muldiv_unit_pkg::XLEN_DEF);

  muldiv_unit_pkg::decode_bus decode_i;
  logic            valid_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_i;
  logic            ok_o;
  logic            flush;
  logic [XLEN-1:0] res_data;
  logic [4:0]      res_adr;
  logic            res_v;
  logic            res_ok;

  modport master (
    output decode_i, valid_i, rs1_i, rs2_i, rd_i, flush, res_ok,
    input  ok_o, res_data, res_adr, res_v
  );

  modport slave (
    input  decode_i, valid_i, rs1_i, rs2_i, rd_i, flush, res_ok,
    output ok_o, res_data, res_adr, res_v
  );

endinterface

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes.
//   rem_i      partial remainder (always < divisor_i)
//   dvd_bit_i  next dividend bit shifted in
//   divisor_i  divisor magnitude
//   q_o        quotient bit produced by this step
//   rem_o      partial remainder for the next step
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            q_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  assign trial = {rem_i, dvd_bit_i};
  assign diff  = trial - {1'b0, divisor_i};
  // trial < 2*divisor, so a non-negative difference always fits in XLEN bits
  // and the top bit of the XLEN+1-bit difference is exactly the borrow.
  assign q_o   = ~diff[XLEN];
  assign rem_o = q_o ? diff[XLEN-1:0] : trial[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execution unit.
//   clk    rising-edge clock
//   rst_n  synchronous reset, active HIGH (1 = reset)
//   bus    muldiv_unit_if.slave: decode_i/valid_i/rs1_i/rs2_i/rd_i/flush in,
//          ok_o out; res_data/res_adr/res_v out, res_ok in
// Build option: MULDIV_FAST_MUL_EN replaces the shift-add multiplier with a
// single registered multiply; multiplies then complete in one cycle.
//
// state | meaning
// IDLE  | ready, waiting for a UNIT_MD instruction
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result presented, waiting for res_ok (or rd == 0)
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = muldiv_unit_pkg::XLEN_DEF
) (
  input logic        clk,
  input logic        rst_n,
  muldiv_unit_if.slave bus
);

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  muldiv_state_e   state, state_nx;
  muldiv_op_e      op_q;
  logic [4:0]      rd_q;
  logic [2*XLEN-1:0] acc;    // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0] opnd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic            neg_res;
  logic            neg_rem;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;

  muldiv_op_e      op_in;
  logic            is_div_in;
  logic            sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, direct_done;
  logic            accept;
  logic            ok, res_v;

  logic [XLEN:0]   mul_sum;
  logic            div_q;
  logic [XLEN-1:0] div_rem;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_s, rem_s, result;

  assign op_in     = muldiv_op_e'(bus.decode_i.sel);
  assign is_div_in = bus.decode_i.sel[2];
  assign sa        = rs1_signed(op_in) & bus.rs1_i[XLEN-1];
  assign sb        = rs2_signed(op_in) & bus.rs2_i[XLEN-1];
  assign a_mag     = sa ? ('0 - bus.rs1_i) : bus.rs1_i;
  assign b_mag     = sb ? ('0 - bus.rs2_i) : bus.rs2_i;
  assign div_zero  = (bus.rs2_i == '0);
  assign div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                     (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.rs2_i == {XLEN{1'b1}});

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a      = {{XLEN{sa}}, bus.rs1_i};
  assign fast_b      = {{XLEN{sb}}, bus.rs2_i};
  assign fast_prod   = fast_a * fast_b;
  assign direct_done = ~is_div_in | div_zero | div_ovf;
`else
  assign direct_done = is_div_in & (div_zero | div_ovf);
`endif

  assign accept = bus.valid_i && (bus.decode_i.unit == UNIT_MD) && ok;
  assign cnt_nx = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit (LSB) is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (acc[2*XLEN-1:XLEN]),
    .dvd_bit_i (acc[XLEN-1]),
    .divisor_i (opnd),
    .q_o       (div_q),
    .rem_o     (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ok       = (state == IDLE) && !bus.flush;
    res_v    = (state == DONE) && (rd_q != 5'd0) && !bus.flush;
    unique case (state)
      IDLE: if (accept) state_nx = direct_done ? DONE : (is_div_in ? DIV : MUL);
      MUL:  if (cnt == CNT_LAST) state_nx = DONE;
      DIV:  if (cnt == CNT_LAST) state_nx = DONE;
      DONE: if (bus.res_ok || (rd_q == 5'd0)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      op_q    <= OP_MUL;
      rd_q    <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            rd_q    <= bus.rd_i;
            cnt     <= '0;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            if (is_div_in) begin
              opnd <= b_mag;
              if (div_zero) begin
                acc     <= {bus.rs1_i, {XLEN{1'b1}}};
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
              end else if (div_ovf) begin
                // rs1 is the most negative value, which is also the quotient
                acc     <= {{XLEN{1'b0}}, bus.rs1_i};
                neg_res <= 1'b0;
                neg_rem <= 1'b0;
              end else begin
                acc <= {{XLEN{1'b0}}, a_mag};
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc     <= fast_prod;
              neg_res <= 1'b0;
`else
              opnd <= a_mag;
              acc  <= {{XLEN{1'b0}}, b_mag};
`endif
            end
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[XLEN-1:1]};
          cnt <= cnt_nx;
        end
        DIV: begin
          acc <= {div_rem, acc[XLEN-2:0], div_q};
          cnt <= cnt_nx;
        end
        default: ;
      endcase
    end
  end

  assign prod  = neg_res ? ('0 - acc) : acc;
  assign quo_s = neg_res ? ('0 - acc[XLEN-1:0]) : acc[XLEN-1:0];
  assign rem_s = neg_rem ? ('0 - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    unique case (op_q)
      OP_MUL:                       result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_s;
      OP_REM, OP_REMU:              result = rem_s;
      default:                      result = '0;
    endcase
  end

  assign bus.ok_o     = ok;
  assign bus.res_v    = res_v;
  assign bus.res_data = (state == DONE) ? result : '0;
  assign bus.res_adr  = (state == DONE) ? rd_q : 5'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XL = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 0;
`else
  localparam int unsigned MUL_LAT = XL;
`endif
  localparam int unsigned DIV_LAT = XL;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_unit_if #(.XLEN(XL)) bus();

  muldiv_unit #(.XLEN(XL)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  adr;
    int unsigned due;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  bit   holding = 0;
  int   checks = 0;
  int   errors = 0;
  bit   bp_en = 0;
  logic res_ok_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Reference model: plain 64-bit arithmetic from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sbv = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub;  return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return 32'(sa / sbv);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'h0; else return 32'(sa % sbv);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int unsigned latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4) begin
      if (b == 0) return 0;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return DIV_LAT;
    end
    return MUL_LAT;
  endfunction

  // res_ok driver: random backpressure or a forced level, applied after the
  // stimulus slot so same-cycle forced changes take effect deterministically.
  always @(posedge clk) begin
    #2;
    bus.res_ok = bp_en ? ($urandom_range(3) != 0) : res_ok_force;
  end

  // Called and returns at posedge+1. n = cyc value of the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_res, output int unsigned n);
    int w = 0;
    n = 0;
    while (!bus.ok_o && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.ok_o) begin
      timeout("issue_wait_ok");
      return;
    end
    bus.decode_i.unit = UNIT_MD;
    bus.decode_i.sel  = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.rd_i    = rd;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    bus.valid_i = 1'b0;
    if (expect_res && rd != 5'd0)
      sb.push_back('{ref_model(op, a, b), rd, n + latency(op, a, b)});
  endtask

  // Monitor: pops on the first cycle of each result, then checks hold stability.
  always @(negedge clk) begin
    if (rst) begin
      holding = 0;
    end else if (bus.res_v) begin
      if (!holding) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res_v: got res_v=1 data 0x%08h adr %0d, required no result",
                   bus.res_data, bus.res_adr);
        end else begin
          cur = sb.pop_front();
          chk("res_data", bus.res_data, cur.data);
          chk("res_adr", 32'(bus.res_adr), 32'(cur.adr));
          chk("latency_cycle", cyc, cur.due);
          holding = 1;
        end
      end else begin
        chk("hold_res_data", bus.res_data, cur.data);
        chk("hold_res_adr", 32'(bus.res_adr), 32'(cur.adr));
      end
      chk("ok_o_in_done", 32'(bus.ok_o), 32'd0);
      if (bus.res_ok) holding = 0;
    end
  end

  initial begin
    vec_t dir[$];
    int unsigned n, n2;
    int w;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int r;

    bus.decode_i = '0;
    bus.valid_i  = 1'b0;
    bus.rs1_i    = '0;
    bus.rs2_i    = '0;
    bus.rd_i     = '0;
    bus.flush    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ok_o", 32'(bus.ok_o), 32'd1);
    chk("rst_res_v", 32'(bus.res_v), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    chk("rst_res_adr", 32'(bus.res_adr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    dir.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5});
    dir.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6});
    dir.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7});
    dir.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8});
    dir.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd9});
    dir.push_back('{3'd5, 32'd100, 32'd7, 5'd10});
    dir.push_back('{3'd7, 32'd100, 32'd7, 5'd11});
    dir.push_back('{3'd4, 32'd5, 32'd0, 5'd12});
    dir.push_back('{3'd6, 32'd5, 32'd0, 5'd13});
    dir.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14});
    dir.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15});
    dir.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd16});
    dir.push_back('{3'd7, 32'hFFFF_FFF9, 32'd0, 5'd17});
    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, dir[i].rd, 1'b1, n);

    // Instruction for another unit is ignored.
    w = 0;
    while (!bus.ok_o && w < 100) begin @(posedge clk); #1; w++; end
    bus.decode_i.unit = 2'd1;
    bus.decode_i.sel  = 3'd4;
    bus.rs1_i = 32'd9; bus.rs2_i = 32'd3; bus.rd_i = 5'd18;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    chk("other_unit_ignored_ok_o", 32'(bus.ok_o), 32'd1);

    // Flush at T+10 of a DIV, then re-issue in T+11.
    issue(3'd4, 32'd1000, 32'd3, 5'd20, 1'b0, n);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    chk("flush_ok_o_next", 32'(bus.ok_o), 32'd1);
    issue(3'd5, 32'd1000, 32'd3, 5'd21, 1'b1, n2);
    chk("flush_reaccept_cycle", n2, n + 11);

    // Flush beats a simultaneous accept.
    w = 0;
    while (!bus.ok_o && w < 100) begin @(posedge clk); #1; w++; end
    bus.decode_i.unit = UNIT_MD;
    bus.decode_i.sel  = 3'd4;
    bus.rs1_i = 32'd50; bus.rs2_i = 32'd5; bus.rd_i = 5'd22;
    bus.valid_i = 1'b1;
    bus.flush   = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.flush   = 1'b0;
    #1;
    chk("flush_vs_accept_ok_o", 32'(bus.ok_o), 32'd1);

    // res_ok held low for 4 cycles in DONE.
    res_ok_force = 1'b0;
    issue(3'd4, 32'd5, 32'd0, 5'd23, 1'b1, n);
    repeat (4) begin
      chk("stall_res_v", 32'(bus.res_v), 32'd1);
      chk("stall_ok_o", 32'(bus.ok_o), 32'd0);
      @(posedge clk); #1;
    end
    res_ok_force = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_ok_o", 32'(bus.ok_o), 32'd1);

    // rd == 0: no res_v, ok_o returns right after DONE.
    issue(3'd5, 32'd100, 32'd7, 5'd0, 1'b1, n);
    w = 0;
    while (!bus.ok_o && w < XL + 10) begin @(posedge clk); #1; w++; end
    if (!bus.ok_o) timeout("rd0_ok_return");
    else chk("rd0_ok_return_cycle", cyc, n + XL + 1);

    // Reset in the middle of a divide.
    issue(3'd5, 32'd300, 32'd7, 5'd24, 1'b0, n);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ok_o", 32'(bus.ok_o), 32'd1);
    chk("midrst_res_v", 32'(bus.res_v), 32'd0);
    chk("midrst_res_data", bus.res_data, 32'd0);
    chk("midrst_res_adr", 32'(bus.res_adr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic with write-back backpressure.
    bp_en = 1;
    for (int i = 0; i < 250; i++) begin
      op = 3'($urandom_range(7));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(9);
      if (r == 0) b = 32'd0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 2) b = 32'($urandom_range(15));
      if (r == 3) a = 32'($urandom_range(15));
      rd = 5'($urandom_range(31));
      issue(op, a, b, rd, 1'b1, n);
    end
    bp_en = 0;

    w = 0;
    while (sb.size() != 0 && w < 200) begin @(posedge clk); w++; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative integer multiply/divide execution unit for the RV32M instructions. Sits directly downstream of the register-manager dispatch stage: it consumes the dispatched decode bus, operand values and destination register, and returns one write-back result (data, address, valid) per accepted instruction. While an operation is in flight it deasserts its ready, which stalls the dispatch pipeline.

## Interface
- `XLEN`, default `cpu_parameters::xlen` (32): operand and result width.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: synchronous reset, active-high (1 = reset); sampled on the rising edge of `clk`.
- `decode_i`, input, `decode_bus`: dispatched decode bus. The instruction is selected when `unit == UNIT_MD`; `sel[2:0]` is funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
- `valid_i`, input, 1: dispatched instruction is valid.
- `rs1_i`, input, XLEN: operand A (dividend or multiplicand).
- `rs2_i`, input, XLEN: operand B (divisor or multiplier).
- `rd_i`, input, 5: destination register.
- `ok_o`, output, 1: ready to accept; connects to the dispatch-stage `ok_i`.
- `flush`, input, 1: pipeline flush; aborts any in-flight operation.
- `res_data`, output, XLEN: write-back data.
- `res_adr`, output, 5: write-back register.
- `res_v`, output, 1: write-back valid.
- `res_ok`, input, 1: write-back port accepted the result this cycle.

## Operation
- Accept: the unit accepts on any cycle with `valid_i && decode_i.unit == UNIT_MD && ok_o`. On accept it latches the op, `rd_i`, operand magnitudes and the result sign.
- Signedness:
  - MULH, DIV and REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - All other ops are unsigned.
- Result sign:
  - Product sign = sign(A) XOR sign(B).
  - Quotient sign is the same as the product sign.
  - Remainder sign = sign(A).
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL on accept of ops 0–3.
  - IDLE→DIV on accept of ops 4–7.
  - IDLE→DONE on accept of a special case (see below).
  - MUL→DONE and DIV→DONE when the counter reaches XLEN-1.
  - DONE→IDLE when `res_ok` is high, or immediately if `rd == 0`.
  - Any state→IDLE on `flush`.
- MUL: shift-add, one multiplier bit per cycle, into a 2·XLEN accumulator. In DONE the product is negated if its sign is set. MUL returns the low half; the MULH variants return the high half.
- DIV: restoring division, one quotient bit per cycle. The XLEN+1-bit subtractor works on magnitudes. In DONE the quotient and remainder get their sign fix-up.
- Special cases (these skip MUL/DIV):
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Signed overflow (0x80000000 / −1): quotient = 0x80000000, remainder = 0.
- Iteration counter: $clog2(XLEN) bits; it wraps to 0 after XLEN-1.
- `rd == 0`: the result is computed but `res_v` is never asserted.
- `flush` in any state drops the operation and produces no `res_v`. A flush has priority over a simultaneous accept and over a simultaneous `res_ok`.

## Timing
- Reset values: state = IDLE, `res_data` = 0, `res_adr` = 0, `res_v` = 0, `ok_o` = 1, counter = 0.
- `ok_o` = (state == IDLE) && !`flush`; it is combinational.
- Latency:
  - Iterative op accepted at edge T: MUL/DIV occupy T+1..T+XLEN, and DONE with `res_v` is at T+XLEN+1 (T+33 for XLEN = 32).
  - Special case: DONE at T+1.
- `res_v` = (state == DONE) && `rd != 0` && !`flush`. It and `res_data`/`res_adr` are held stable until `res_ok`.
- Throughput: a new instruction can be accepted in the cycle after DONE→IDLE; there is no accept while in DONE.
- Reset mid-operation: the next cycle is IDLE with all outputs at their reset values.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: multiply uses one registered 2·XLEN `*` of the sign-extended (XLEN+1)-bit operands. MUL ops go IDLE→DONE with latency T+1, and the MUL state is never entered.
  - Undefined: the iterative shift-add described above is used.
  - Divide behaviour is identical in both builds.

## Structure
- Additions to `cpu_parameters`: `UNIT_MD` constant and a `muldiv_op_e` enum for funct3.
- Additions to `interfaces_pkg`: `muldiv_state_e` enum.
- One sub-module, `div_step`: a combinational single restoring-division iteration (remainder in, quotient bit and remainder out). `muldiv_unit` instantiates it once and iterates it XLEN times.

## Test plan
- MUL 7 × −3, rd = 5: `res_v` at T+33 with `res_data` = 0xFFFFFFEB and `res_adr` = 5; at T+1 with `MULDIV_FAST_MUL_EN` defined.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → −3 (0xFFFFFFFD). REM −7 / 2 → −1. DIVU 100 / 7 → 14. REMU 100 / 7 → 2. All at T+33.
- DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, both at T+1. DIV 0x80000000 / −1 → 0x80000000 at T+1.
- `flush` at T+10 of a DIV: `res_v` is never asserted, `ok_o` = 1 at T+11, and a new DIVU issued at T+11 is accepted and completes correctly.
- `res_ok` held low for 4 cycles in DONE: `res_v`/`res_data` stay stable and `ok_o` = 0. An op with rd = 0 produces no `res_v` and `ok_o` returns to 1 after DONE.
